inst_fetch: RTL

INST_FETCH -- requirements
Module: inst_fetch

---
 rtl/inst_fetch_pkg.sv | 27 ++
 rtl/inst_fetch.sv | 123 ++++++++++++
 2 files changed

// File: rtl/inst_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : inst_fetch_pkg
// Description : Shared constants and state encodings for the instruction fetch
//               stage.
// Revision    : 1.0 - initial release
// ============================================================================
package inst_fetch_pkg;

    localparam logic        RstEnable   = 1'b0;
    localparam logic        Stop        = 1'b1;
    localparam logic        NoStop      = 1'b0;
    localparam int          InstAddrBus = 32;
    localparam int          InstBus     = 32;
    localparam logic [31:0] ZeroWord    = 32'h0000_0000;

    localparam logic [1:0]  ST_IDLE     = 2'd0;
    localparam logic [1:0]  ST_WAIT     = 2'd1;
    localparam logic [1:0]  ST_VALID    = 2'd2;
    localparam logic [1:0]  ST_KILL     = 2'd3;

    function automatic logic [InstAddrBus-1:0] word_align(input logic [InstAddrBus-1:0] addr);
        return {addr[InstAddrBus-1:2], 2'b00};
    endfunction

endpackage
`default_nettype wire

// File: rtl/inst_fetch.sv
`default_nettype none
// ============================================================================
// Module      : inst_fetch
// Description : Instruction fetch stage with IDLE/WAIT/VALID/KILL handshake
//               FSM. Define FETCH_PREFETCH_EN to fetch back-to-back from VALID.
// Revision    : 1.0 - initial release
// ============================================================================
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [5:0]             stall,
    input  logic                   flush,
    input  logic [InstAddrBus-1:0] new_pc,
    input  logic                   branch_flag,
    input  logic [InstAddrBus-1:0] branch_target,
    output logic                   rom_req,
    output logic [InstAddrBus-1:0] rom_addr,
    input  logic                   rom_ack,
    input  logic [InstBus-1:0]     rom_data,
    output logic [InstAddrBus-1:0] if_pc,
    output logic [InstBus-1:0]     if_inst,
    output logic                   stallreq_if
);

`ifdef FETCH_PREFETCH_EN
    localparam logic [1:0] ADVANCE_ST = ST_WAIT;
`else
    localparam logic [1:0] ADVANCE_ST = ST_IDLE;
`endif

    logic [1:0]             state_q, state_d;
    logic [InstAddrBus-1:0] pc_q, pc_d;
    logic [InstBus-1:0]     inst_q, inst_d;
    logic [InstAddrBus-1:0] kill_addr_q, kill_addr_d;

    logic                   redirect;
    logic [InstAddrBus-1:0] target;
    logic [InstAddrBus-1:0] pc_inc;
    logic                   unused_stall;

    assign redirect     = flush | (branch_flag & (stall[0] == NoStop));
    assign target       = word_align(flush ? new_pc : branch_target);
    assign pc_inc       = pc_q + 32'd4;
    assign unused_stall = ^stall[5:1];

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            state_q     <= ST_IDLE;
            pc_q        <= word_align(RESET_PC);
            inst_q      <= ZeroWord;
            kill_addr_q <= ZeroWord;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            inst_q      <= inst_d;
            kill_addr_q <= kill_addr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        inst_d      = inst_q;
        kill_addr_d = kill_addr_q;
        case (state_q)
            ST_IDLE: begin
                state_d = ST_WAIT;
                if (redirect) begin
                    pc_d = target;
                end
            end
            ST_WAIT: begin
                if (redirect) begin
                    pc_d = target;
                    if (rom_ack) begin
                        state_d = ST_WAIT;
                    end else begin
                        // Memory still owes a response for the old address.
                        state_d     = ST_KILL;
                        kill_addr_d = pc_q;
                    end
                end else if (rom_ack) begin
                    inst_d  = rom_data;
                    state_d = ST_VALID;
                end
            end
            ST_VALID: begin
                if (redirect) begin
                    pc_d    = target;
                    state_d = ADVANCE_ST;
                end else if (stall[0] == NoStop) begin
                    pc_d    = pc_inc;
                    state_d = ADVANCE_ST;
                end
            end
            ST_KILL: begin
                if (redirect) begin
                    pc_d = target;
                end
                if (rom_ack) begin
                    state_d = ST_WAIT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        rom_req     = (state_q == ST_WAIT) || (state_q == ST_KILL);
        rom_addr    = (state_q == ST_KILL) ? kill_addr_q : pc_q;
        if_pc       = pc_q;
        if_inst     = (state_q == ST_VALID) ? inst_q : ZeroWord;
        stallreq_if = (state_q != ST_VALID);
    end

endmodule
`default_nettype wire
